// File: rtl/frame_minmax_tracker.sv
// Frame min/max tracker: scans FRAME_LEN unsigned samples over a valid/ready
// stream and reports the extremes and the first index at which each occurred.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; not ready, not busy
// FIRST | ready for sample 0; seeds both working extremes
// RUN   | ready for samples 1..FRAME_LEN-1; strict compare vs extremes
// DONE  | one-cycle done pulse; results were loaded on entry
module frame_minmax_tracker #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] min_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One extra counter bit so the last-index compare never sees a wrapped value.
  localparam int              LAST_IDX_INT = FRAME_LEN - 1;
  localparam logic [IDX_W:0]  LAST_IDX     = LAST_IDX_INT[IDX_W:0];
  localparam logic [IDX_W:0]  CNT_ONE      = {{IDX_W{1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [IDX_W:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] wk_max, wk_max_nxt;
  logic [WIDTH-1:0] wk_min, wk_min_nxt;
  logic [IDX_W-1:0] wk_max_idx, wk_max_idx_nxt;
  logic [IDX_W-1:0] wk_min_idx, wk_min_idx_nxt;
  logic             last_accept;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    wk_max_nxt     = wk_max;
    wk_min_nxt     = wk_min;
    wk_max_idx_nxt = wk_max_idx;
    wk_min_idx_nxt = wk_min_idx;
    last_accept    = 1'b0;
    in_ready       = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FIRST;
          cnt_nxt   = '0;
        end
      end

      S_FIRST: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          wk_max_nxt     = in_data;
          wk_min_nxt     = in_data;
          wk_max_idx_nxt = '0;
          wk_min_idx_nxt = '0;
          cnt_nxt        = CNT_ONE;
          state_nxt      = S_RUN;
        end
      end

      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          // Strict compares keep the first occurrence on ties.
          if (in_data > wk_max) begin
            wk_max_nxt     = in_data;
            wk_max_idx_nxt = cnt[IDX_W-1:0];
          end
          if (in_data < wk_min) begin
            wk_min_nxt     = in_data;
            wk_min_idx_nxt = cnt[IDX_W-1:0];
          end
          cnt_nxt = cnt + CNT_ONE;
          if (cnt == LAST_IDX) begin
            last_accept = 1'b1;
            state_nxt   = S_DONE;
          end
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wk_max     <= '0;
      wk_min     <= '0;
      wk_max_idx <= '0;
      wk_min_idx <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wk_max     <= wk_max_nxt;
      wk_min     <= wk_min_nxt;
      wk_max_idx <= wk_max_idx_nxt;
      wk_min_idx <= wk_min_idx_nxt;
    end
  end

  // Results load from the next-state working values so the final sample is
  // already folded in while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
      min_val <= '1;
      max_idx <= '0;
      min_idx <= '0;
    end else if (last_accept) begin
      max_val <= wk_max_nxt;
      min_val <= wk_min_nxt;
      max_idx <= wk_max_idx_nxt;
      min_idx <= wk_min_idx_nxt;
    end
  end

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Bench for frame_minmax_tracker: queue-based frame model compared every cycle,
// directed frames with literal results, then randomized frames.
module tb_frame_minmax_tracker;
  localparam int W  = 8;
  localparam int FL = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, busy, done;
  logic [W-1:0]  max_val, min_val;
  logic [IW-1:0] max_idx, min_idx;

  frame_minmax_tracker #(.WIDTH(W), .FRAME_LEN(FL), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .busy(busy), .done(done),
    .max_val(max_val), .min_val(min_val), .max_idx(max_idx), .min_idx(min_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 collecting samples, 2 done cycle.
  int            m_phase;
  logic [W-1:0]  q[$];
  logic [W-1:0]  m_max, m_min;
  logic [IW-1:0] m_max_idx, m_min_idx;

  task automatic finish_frame();
    logic [W-1:0] ext[$];
    int           pos[$];
    ext = q.max();
    m_max = ext[0];
    pos = q.find_first_index(x) with (x == m_max);
    m_max_idx = IW'(pos[0]);
    ext = q.min();
    m_min = ext[0];
    pos = q.find_first_index(x) with (x == m_min);
    m_min_idx = IW'(pos[0]);
    q.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   = 0;
      q.delete();
      m_max     = '0;
      m_min     = '1;
      m_max_idx = '0;
      m_min_idx = '0;
    end else begin
      case (m_phase)
        0: if (start) m_phase = 1;
        1: if (in_valid) begin
             q.push_back(in_data);
             if (q.size() == FL) begin
               finish_frame();
               m_phase = 2;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_phase == 1);
    chk("busy", busy, m_phase == 1);
    chk("done", done, m_phase == 2);
    chk("max_val", max_val, m_max);
    chk("min_val", min_val, m_min);
    chk("max_idx", max_idx, m_max_idx);
    chk("min_idx", min_idx, m_min_idx);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  task automatic run_frame(input logic [W-1:0] s0, s1, s2, s3,
                           input bit bubbles, input bit mid_start);
    logic [W-1:0] s[4];
    s = '{s0, s1, s2, s3};
    @(posedge clk); #2;
    start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;  // same-cycle sample must be ignored
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        start    = (mid_start && i == 2);
        @(posedge clk); #2;
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = s[i];
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic chk_results(input string name, input logic [W-1:0] mx, mn,
                             input logic [IW-1:0] mxi, mni);
    chk({name, "_max_val"}, max_val, mx);
    chk({name, "_min_val"}, min_val, mn);
    chk({name, "_max_idx"}, max_idx, mxi);
    chk({name, "_min_idx"}, min_idx, mni);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk_results(name, 8'h00, 8'hFF, 2'd0, 2'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_reset_outputs("por");

    // Basic frame, back-to-back
    busy_cnt = 0; done_cnt = 0;
    run_frame(8'd20, 8'd200, 8'd5, 8'd99, 0, 0);
    wait_done("basic");
    chk_results("basic", 8'd200, 8'd5, 2'd1, 2'd2);
    repeat (2) @(negedge clk);
    chk("basic_busy_cycles", busy_cnt, 4);
    chk("basic_done_pulses", done_cnt, 1);

    // Asynchronous reset mid-cycle clears results immediately
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(posedge clk); #3 rst_n = 1'b1;

    // Ties
    run_frame(8'd7, 8'd7, 8'd7, 8'd7, 0, 0);
    wait_done("ties_eq");
    chk_results("ties_eq", 8'd7, 8'd7, 2'd0, 2'd0);
    run_frame(8'd0, 8'd255, 8'd255, 8'd0, 0, 0);
    wait_done("ties_ext");
    chk_results("ties_ext", 8'd255, 8'd0, 2'd1, 2'd0);

    // Bubbles with a mid-frame start
    repeat (2) @(posedge clk);
    done_cnt = 0;
    run_frame(8'd20, 8'd200, 8'd5, 8'd99, 1, 1);
    wait_done("bubble");
    chk_results("bubble", 8'd200, 8'd5, 2'd1, 2'd2);
    repeat (4) @(negedge clk);
    chk("bubble_done_pulses", done_cnt, 1);

    // Reset after two of four samples
    done_cnt = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0; in_valid = 1'b1; in_data = 8'd50;
    @(posedge clk); #2 in_data = 8'd60;
    @(posedge clk); #2 in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    run_frame(8'd1, 8'd2, 8'd3, 8'd4, 0, 0);
    wait_done("after_rst");
    chk_results("after_rst", 8'd4, 8'd1, 2'd3, 2'd0);

    // Randomized frames with bubbles, stray starts and tie-prone data
    for (int f = 0; f < 50; f++) begin
      bit got = 0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
        start    = ($urandom_range(0, 9) == 0);
        @(posedge clk); #2;
        if (done) got = 1;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (!got) chk("random_frame_timeout", 0, 1);
    end
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/frame_minmax_tracker.md
Name: frame_minmax_tracker

Overview:
- Sequential stage downstream of the team's N-bit magnitude comparator; each accepted sample is compared against the running extremes.
- Scans a frame of FRAME_LEN unsigned samples over a valid/ready stream.
- Reports the frame maximum, minimum and the index of each.
- Used for frame statistics and peak detection ahead of downstream sorting and threshold logic.

Parameters:
- WIDTH, 8: sample width in bits, unsigned.
- FRAME_LEN, 16: samples per frame; minimum 2.
- IDX_W, 4: index width; must satisfy 2^IDX_W >= FRAME_LEN.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new frame; sampled only in IDLE.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  WIDTH  sample value, unsigned.
- in_ready  output  1  block accepts a sample this cycle.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse: frame complete, results updated.
- max_val  output  WIDTH  largest sample of the last completed frame.
- min_val  output  WIDTH  smallest sample of the last completed frame.
- max_idx  output  IDX_W  index (0-based) of max_val within its frame.
- min_idx  output  IDX_W  index (0-based) of min_val within its frame.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - in_ready, busy and done are 0.
  - max_val, max_idx and min_idx are 0.
  - min_val is all-ones.
  - Sample counter and working registers are cleared.
- Handshake:
  - A sample is accepted on a rising edge where in_valid=1 and in_ready=1.
  - in_ready is driven from state only (FIRST or RUN) and never from in_valid.
  - Samples presented while in_ready=0 are ignored and not stored.
- FSM:
  - IDLE: in_ready=0, busy=0. start=1 -> FIRST; counter cleared.
  - FIRST: in_ready=1, busy=1. On accept, the working max and working min both load in_data, both working indices load 0, counter=1, then -> RUN.
  - RUN: in_ready=1, busy=1. On accept:
    - If in_data > working max (strict), the working max loads in_data and its index loads the counter.
    - If in_data < working min (strict), the working min loads in_data and its index loads the counter.
    - Both updates may occur in the same cycle only if they are not mutually exclusive; with the strict compares they never are.
    - The counter increments.
    - If the accepted sample is index FRAME_LEN-1 -> DONE.
  - DONE: in_ready=0, busy=0. For exactly one cycle:
    - done=1.
    - max_val, min_val, max_idx and min_idx load the working registers, the final sample included.
    - Then -> IDLE.
- Latency: done rises on the cycle after the edge that accepts the final sample.
- Ties: the strict compare keeps the first occurrence. A later equal value never moves an index.
- Result outputs hold their values from DONE until the next DONE or reset. They do not change during a frame.
- start while busy=1 or in DONE is ignored; it is not queued.
- start and in_valid in the same IDLE cycle: the sample is not accepted, because in_ready=0 in IDLE.
- in_valid gaps (bubbles) inside a frame stall the frame indefinitely. No timeout.
- All-equal frame: max_val = min_val = that value, and both indices are 0.
- Reset mid-frame: the frame is abandoned, all outputs return to their reset values, and no done pulse is produced.
- Comparisons are unsigned at full WIDTH. Counter width is IDX_W+1 to avoid wrap before the final-sample compare.

Test Plan:
1. Reset with rst_n=0 asynchronously mid-cycle -> outputs go immediately to in_ready=0, busy=0, done=0, max_val=0, min_val=8'hFF, both indices 0.
2. FRAME_LEN=4, start, then samples 20, 200, 5, 99 back-to-back -> done 1 cycle after the 4th accept. max_val=200, max_idx=1, min_val=5, min_idx=2. busy is high for exactly 4 cycles.
3. Ties, FRAME_LEN=4, samples 7, 7, 7, 7 -> max_val=min_val=7, max_idx=min_idx=0. Then a second frame of 0, 255, 255, 0 -> max_idx=1, min_idx=0.
4. Bubbles and ignored start: toggle in_valid every other cycle, and pulse start mid-frame -> results are identical to the gap-free run. Exactly one done pulse per frame; the mid-frame start has no effect.
5. Reset mid-frame: after 2 of 4 samples, assert rst_n=0 -> no done pulse, outputs at reset values. A new frame of 1, 2, 3, 4 then gives max_val=4/max_idx=3 and min_val=1/min_idx=0.
6. Randomized: 50 frames of {$random} samples against a reference model of max/min/first-index -> zero mismatches. Results are stable between done pulses.
